mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port RAM with a registered read port.
// Each access takes three cycles: arbitrate (IDLE), drive the RAM (ISSUE), respond (RESP).
module mem_arbiter #(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_wr,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_wr,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_err,

    output logic        ram_en,
    output logic        ram_wr,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,

    output logic        busy
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t        state;
    logic          grant;
    logic          last_grant;
    logic          wr_q;
    logic          err_q;

    logic          winner;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_wr;
    logic          sel_mis;

    // Winner selection: alternate on contention unless m0 has fixed priority
    always_comb begin
        winner = 1'b0;
        if (m0_req && m1_req) begin
            winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
        end else begin
            winner = m1_req;
        end
        sel_addr  = winner ? m1_addr  : m0_addr;
        sel_wdata = winner ? m1_wdata : m0_wdata;
        sel_wr    = winner ? m1_wr    : m0_wr;
        sel_mis   = (sel_addr[1:0] != 2'b00);
    end

    // The RAM drive registers double as the latched request copy during ISSUE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            ram_en     <= 1'b0;
            ram_wr     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m1_err     <= 1'b0;
        end else begin
            ram_en    <= 1'b0;
            ram_wr    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_err    <= 1'b0;
            m1_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        state      <= ISSUE;
                        grant      <= winner;
                        last_grant <= winner;
                        wr_q       <= sel_wr;
                        err_q      <= sel_mis;
                        ram_en     <= ~sel_mis;
                        ram_wr     <= ~sel_mis & sel_wr;
                        ram_addr   <= sel_addr;
                        ram_wdata  <= sel_wdata;
                    end
                end
                ISSUE: begin
                    state <= RESP;
                    if (grant) begin
                        m1_ack <= 1'b1;
                        m1_err <= err_q;
                    end else begin
                        m0_ack <= 1'b1;
                        m0_err <= err_q;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // RAM read data only exists during RESP, so it is gated rather than registered
    assign m0_rdata = (m0_ack && !wr_q && !err_q) ? ram_rdata : '0;
    assign m1_rdata = (m1_ack && !wr_q && !err_q) ? ram_rdata : '0;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin and a fixed-priority instance
// share requester stimulus, each with its own one-cycle-latency RAM model.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        preload;

    logic        m0_req, m1_req, m0_wr, m1_wr;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;

    logic        a_m0_ack, a_m1_ack, a_m0_err, a_m1_err, a_busy;
    logic [31:0] a_m0_rdata, a_m1_rdata;
    logic        a_ram_en, a_ram_wr;
    logic [31:0] a_ram_addr, a_ram_wdata, a_ram_rdata;

    logic        b_m0_ack, b_m1_ack, b_m0_err, b_m1_err, b_busy;
    logic [31:0] b_m0_rdata, b_m1_rdata;
    logic        b_ram_en, b_ram_wr;
    logic [31:0] b_ram_addr, b_ram_wdata, b_ram_rdata;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];

    int errors;
    int checks;
    int en_cnt;
    int wr_cnt;
    int both_cnt;

    mem_arbiter #(.FIXED_PRIO(0)) dut_rr (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wr(m0_wr),
        .m0_ack(a_m0_ack), .m0_rdata(a_m0_rdata), .m0_err(a_m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wr(m1_wr),
        .m1_ack(a_m1_ack), .m1_rdata(a_m1_rdata), .m1_err(a_m1_err),
        .ram_en(a_ram_en), .ram_wr(a_ram_wr), .ram_addr(a_ram_addr),
        .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata), .busy(a_busy)
    );

    mem_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wr(m0_wr),
        .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata), .m0_err(b_m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wr(m1_wr),
        .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata), .m1_err(b_m1_err),
        .ram_en(b_ram_en), .ram_wr(b_ram_wr), .ram_addr(b_ram_addr),
        .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: word-indexed, read data registered one cycle after ram_en
    always @(posedge clk) begin
        if (preload) begin
            mem_a[64] <= 32'hDEADBEEF;
            mem_a[16] <= 32'hCAFEF00D;
            a_ram_rdata <= 32'h0;
        end else if (a_ram_en) begin
            if (a_ram_wr) mem_a[a_ram_addr[9:2]] <= a_ram_wdata;
            else          a_ram_rdata <= mem_a[a_ram_addr[9:2]];
        end
    end

    always @(posedge clk) begin
        if (preload) begin
            mem_b[64] <= 32'hDEADBEEF;
            mem_b[16] <= 32'hCAFEF00D;
            b_ram_rdata <= 32'h0;
        end else if (b_ram_en) begin
            if (b_ram_wr) mem_b[b_ram_addr[9:2]] <= b_ram_wdata;
            else          b_ram_rdata <= mem_b[b_ram_addr[9:2]];
        end
    end

    // Activity monitors on the round-robin instance, sampled mid-cycle
    initial begin
        en_cnt = 0;
        wr_cnt = 0;
        both_cnt = 0;
        forever begin
            @(negedge clk);
            if (a_ram_en) en_cnt++;
            if (a_ram_wr) wr_cnt++;
            if ((a_m0_ack && a_m1_ack) || (b_m0_ack && b_m1_ack)) both_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wr = 1'b0;
        m1_req = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int base_en;
        int base_wr;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        preload = 1'b1;
        idle_inputs();
        #1;
        check("rst_ram_en", 32'(a_ram_en), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_acks", {30'd0, a_m0_ack, a_m1_ack}, 32'd0);
        tick();
        preload = 1'b0;
        do_reset();

        // Single aligned read by m0
        m0_req = 1'b1; m0_addr = 32'h100; m0_wr = 1'b0;
        tick();
        check("rd_issue_en", 32'(a_ram_en), 32'd1);
        check("rd_issue_addr", a_ram_addr, 32'h100);
        check("rd_issue_wr", 32'(a_ram_wr), 32'd0);
        check("rd_issue_busy", 32'(a_busy), 32'd1);
        check("rd_issue_noack", 32'(a_m0_ack), 32'd0);
        tick();
        check("rd_ack", 32'(a_m0_ack), 32'd1);
        check("rd_rdata", a_m0_rdata, 32'hDEADBEEF);
        check("rd_err", 32'(a_m0_err), 32'd0);
        check("rd_resp_busy", 32'(a_busy), 32'd1);
        check("rd_resp_en", 32'(a_ram_en), 32'd0);
        m0_req = 1'b0;
        tick();
        check("rd_idle_busy", 32'(a_busy), 32'd0);
        check("rd_idle_ack", 32'(a_m0_ack), 32'd0);
        check("rd_idle_rdata", a_m0_rdata, 32'h0);

        // Contention from reset, both held continuously; m0 drops after its 4th fixed-prio ack
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h100; m0_wr = 1'b0;
        m1_req = 1'b1; m1_addr = 32'h040; m1_wr = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            check($sformatf("rr_m0_ack_%0d", i), 32'(a_m0_ack), 32'((i == 2) || (i == 8)));
            check($sformatf("rr_m1_ack_%0d", i), 32'(a_m1_ack), 32'((i == 5) || (i == 11) || (i == 14)));
            check($sformatf("fp_m0_ack_%0d", i), 32'(b_m0_ack), 32'((i == 2) || (i == 5) || (i == 8) || (i == 11)));
            check($sformatf("fp_m1_ack_%0d", i), 32'(b_m1_ack), 32'(i == 14));
            if (i == 2) begin
                check("rr_m0_rdata", a_m0_rdata, 32'hDEADBEEF);
                check("rr_m1_rdata_idle", a_m1_rdata, 32'h0);
            end
            if (i == 5) check("rr_m1_rdata", a_m1_rdata, 32'hCAFEF00D);
            if (i == 11) m0_req = 1'b0;
        end
        m1_req = 1'b0;
        tick();
        tick();

        // m1 write then read back at 0x40
        do_reset();
        base_wr = wr_cnt;
        m1_req = 1'b1; m1_addr = 32'h040; m1_wdata = 32'h12345678; m1_wr = 1'b1;
        tick();
        check("wr_issue_en", 32'(a_ram_en), 32'd1);
        check("wr_issue_wr", 32'(a_ram_wr), 32'd1);
        check("wr_issue_wdata", a_ram_wdata, 32'h12345678);
        check("wr_issue_addr", a_ram_addr, 32'h040);
        tick();
        check("wr_ack", 32'(a_m1_ack), 32'd1);
        check("wr_rdata_zero", a_m1_rdata, 32'h0);
        check("wr_err", 32'(a_m1_err), 32'd0);
        m1_req = 1'b0;
        tick();
        m1_req = 1'b1; m1_wr = 1'b0; m1_wdata = 32'h0;
        tick();
        check("rb_issue_wr", 32'(a_ram_wr), 32'd0);
        m1_addr = 32'h100;
        tick();
        check("rb_ack", 32'(a_m1_ack), 32'd1);
        check("rb_rdata", a_m1_rdata, 32'h12345678);
        m1_req = 1'b0;
        tick();
        check("wr_cycles", 32'(wr_cnt - base_wr), 32'd1);

        // Misaligned read: no RAM access, error flagged, rdata forced low
        do_reset();
        base_en = en_cnt;
        m0_req = 1'b1; m0_addr = 32'h102; m0_wr = 1'b0;
        tick();
        check("mis_issue_en", 32'(a_ram_en), 32'd0);
        check("mis_issue_busy", 32'(a_busy), 32'd1);
        tick();
        check("mis_ack", 32'(a_m0_ack), 32'd1);
        check("mis_err", 32'(a_m0_err), 32'd1);
        check("mis_rdata", a_m0_rdata, 32'h0);
        m0_req = 1'b0;
        tick();
        check("mis_err_clear", 32'(a_m0_err), 32'd0);
        check("mis_en_cycles", 32'(en_cnt - base_en), 32'd0);

        // Reset while an m0 write is in ISSUE
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h100; m0_wdata = 32'h55AA55AA; m0_wr = 1'b1;
        tick();
        check("abort_issue_en", 32'(a_ram_en), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("abort_en_drop", 32'(a_ram_en), 32'd0);
        check("abort_wr_drop", 32'(a_ram_wr), 32'd0);
        check("abort_busy_drop", 32'(a_busy), 32'd0);
        tick();
        check("abort_noack", 32'(a_m0_ack), 32'd0);
        check("abort_mem_kept", mem_a[64], 32'hDEADBEEF);
        rst = 1'b0;
        tick();
        check("retry_issue_en", 32'(a_ram_en), 32'd1);
        check("retry_noack_yet", 32'(a_m0_ack), 32'd0);
        check("retry_mem_kept", mem_a[64], 32'hDEADBEEF);
        tick();
        check("retry_ack", 32'(a_m0_ack), 32'd1);
        check("retry_rdata", a_m0_rdata, 32'h0);
        check("retry_mem_written", mem_a[64], 32'h55AA55AA);
        m0_req = 1'b0;
        tick();
        tick();

        check("acks_exclusive", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
